// File: rtl/timer_pkg.sv
// timer_pkg
// Shared definitions for the period timer controller: register addresses,
// CTRL/STATUS bit positions, FSM state encoding and the selector period
// table that the timer itself also uses.
//
// CTRL layout:   [0] enable  [1] mode (0 one-shot, 1 periodic)
//                [4:2] period selector  [5] irq_en (needs DATA_W > 5)
// STATUS layout: [0] pending [1] running [2] overrun (write 1 to clear)
package timer_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_TARGET  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_SEL_LSB = 2;
    localparam int CTRL_SEL_MSB = 4;
    localparam int CTRL_IRQ_EN  = 5;

    localparam int STAT_PENDING = 0;
    localparam int STAT_RUNNING = 1;
    localparam int STAT_OVERRUN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        FIRE = 2'd3
    } timerState_e;

    // Timer period in clock cycles for each selector code.
    function automatic logic [15:0] selPeriod(input logic [2:0] sel);
        logic [15:0] period;
        case (sel)
            3'd0:    period = 16'd16;
            3'd1:    period = 16'd32;
            3'd2:    period = 16'd64;
            3'd3:    period = 16'd128;
            3'd4:    period = 16'd256;
            3'd5:    period = 16'd512;
            3'd6:    period = 16'd1024;
            default: period = 16'd2048;
        endcase
        return period;
    endfunction

endpackage

// File: rtl/timer_edge_det.sv
// timer_edge_det
// One-cycle rising-edge detector: a level held high for several cycles
// yields exactly one pulse on the first cycle it is seen high.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   sig_i  - level input (timer expiry)
//   rise_o - high for the cycle in which sig_i is high but was low before
module timer_edge_det (
    input  logic clock,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // Remember last cycle's level of the input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl
// CPU-facing controller for the period timer. Holds CTRL/TARGET/STATUS
// registers, drives the timer's reset/enable/selector, counts timer tick
// pulses up to TARGET+1 and raises a maskable interrupt with a
// pending/acknowledge handshake. One-shot and periodic modes.
//
// Ports:
//   clock, reset        - system clock; asynchronous active-low reset
//   we, addr, wdata     - register write strobe, register select, write data
//   rdata               - combinational read data for addr
//   irq_ack, irq        - interrupt acknowledge in, masked interrupt out
//   tmr_tick            - timer expiry level from the timer
//   tmr_reset           - active-high reset to the timer
//   tmr_active          - timer count enable
//   tmr_selector        - timer period select
//
// Build option: define TIMER_CTRL_CAPTURE_EN to add the CAPTURE register
// (count of total fires, readable at address 3). Without it address 3
// reads zero.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              irq_ack,
    output logic              irq,
    input  logic              tmr_tick,
    output logic              tmr_reset,
    output logic              tmr_active,
    output logic [2:0]        tmr_selector
);

    timerState_e      state_q, state_d;
    logic             enable_q, enable_d;
    logic             mode_q, mode_d;
    logic             irqEn_q, irqEn_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] tickCnt_q, tickCnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;

    logic             tickEvt;
    logic             ctrlWr, targetWr, statusWr;
    logic [5:0]       wdataLo;
    logic             wrEnable, wrMode, wrIrqEn;
    logic [2:0]       wrSel;
    logic             cfgChange;
    logic             running;
    logic [5:0]       ctrlBits;

    timer_edge_det uEdgeDet (
        .clock  (clock),
        .reset  (reset),
        .sig_i  (tmr_tick),
        .rise_o (tickEvt)
    );

    assign ctrlWr   = we && (addr == ADDR_CTRL);
    assign targetWr = we && (addr == ADDR_TARGET);
    assign statusWr = we && (addr == ADDR_STATUS);

    // The control fields live in the low six bits; resizing first keeps the
    // indexing legal when DATA_W is only 5. With no room for irq_en the
    // interrupt is left permanently unmasked.
    assign wdataLo   = 6'(wdata);
    assign wrEnable  = wdataLo[CTRL_ENABLE];
    assign wrMode    = wdataLo[CTRL_MODE];
    assign wrSel     = wdataLo[CTRL_SEL_MSB:CTRL_SEL_LSB];
    assign wrIrqEn   = (DATA_W > CTRL_IRQ_EN) ? wdataLo[CTRL_IRQ_EN] : 1'b1;
    assign cfgChange = (wrSel != sel_q) || (wrMode != mode_q);

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A CTRL write overrides the normal sequence: clearing
    // enable always stops, and a new mode/selector restarts through ARM. A
    // one-shot FIRE that is re-enabled in the same cycle also restarts,
    // so the FSM agrees with the enable bit the write leaves behind.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = IDLE;
            ARM:  state_d = RUN;
            RUN:  if (tickEvt && (tickCnt_q == target_q)) state_d = FIRE;
            FIRE: state_d = mode_q ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
        if (ctrlWr) begin
            if (!wrEnable) begin
                state_d = IDLE;
            end else if ((state_q == IDLE) || cfgChange ||
                         ((state_q == FIRE) && !mode_q)) begin
                state_d = ARM;
            end
        end
    end

    // FSM outputs. The timer is held in reset while idle or arming and keeps
    // counting through FIRE so periodic mode loses no time.
    always_comb begin
        tmr_reset  = 1'b0;
        tmr_active = 1'b0;
        running    = 1'b1;
        case (state_q)
            IDLE: begin
                tmr_reset = 1'b1;
                running   = 1'b0;
            end
            ARM:     tmr_reset  = 1'b1;
            RUN:     tmr_active = 1'b1;
            FIRE:    tmr_active = 1'b1;
            default: tmr_reset  = 1'b1;
        endcase
    end

    // Register next-state logic. FIRE beats a simultaneous acknowledge, and
    // an acknowledge in the FIRE cycle suppresses the overrun flag.
    always_comb begin
        enable_d  = enable_q;
        mode_d    = mode_q;
        sel_d     = sel_q;
        irqEn_d   = irqEn_q;
        target_d  = target_q;
        tickCnt_d = tickCnt_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        if (ctrlWr) begin
            enable_d = wrEnable;
            mode_d   = wrMode;
            sel_d    = wrSel;
            irqEn_d  = wrIrqEn;
        end else if ((state_q == FIRE) && !mode_q) begin
            enable_d = 1'b0;
        end

        if (targetWr) begin
            target_d = CNT_W'(wdata);
        end

        case (state_q)
            ARM: tickCnt_d = '0;
            RUN: if (tickEvt && (tickCnt_q != target_q)) tickCnt_d = tickCnt_q + CNT_W'(1);
            FIRE: if (mode_q) tickCnt_d = '0;
            default: tickCnt_d = tickCnt_q;
        endcase

        if (state_q == FIRE) begin
            pending_d = 1'b1;
        end else if (irq_ack) begin
            pending_d = 1'b0;
        end

        if (statusWr && wdataLo[STAT_OVERRUN]) begin
            overrun_d = 1'b0;
        end
        if ((state_q == FIRE) && pending_q && !irq_ack) begin
            overrun_d = 1'b1;
        end
    end

    // Register storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_q  <= 1'b0;
            mode_q    <= 1'b0;
            sel_q     <= 3'd0;
            irqEn_q   <= 1'b0;
            target_q  <= '0;
            tickCnt_q <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            sel_q     <= sel_d;
            irqEn_q   <= irqEn_d;
            target_q  <= target_d;
            tickCnt_q <= tickCnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef TIMER_CTRL_CAPTURE_EN
    // CAPTURE always equals the running fire count, so one counter serves
    // as both the free-running count and its latched copy.
    logic [CNT_W-1:0] capture_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            capture_q <= '0;
        end else if (state_q == FIRE) begin
            capture_q <= capture_q + CNT_W'(1);
        end
    end
`endif

    assign ctrlBits     = {irqEn_q, sel_q, mode_q, enable_q};
    assign irq          = pending_q & irqEn_q;
    assign tmr_selector = sel_q;

    // Combinational read mux.
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = DATA_W'(ctrlBits);
            ADDR_TARGET: rdata = DATA_W'(target_q);
            ADDR_STATUS: rdata = DATA_W'({overrun_q, running, pending_q});
`ifdef TIMER_CTRL_CAPTURE_EN
            ADDR_CAPTURE: rdata = DATA_W'(capture_q);
`else
            ADDR_CAPTURE: rdata = '0;
`endif
            default:     rdata = '0;
        endcase
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- CPU-facing controller that configures and sequences the period timer.
- Drives the timer's reset, enable and 3-bit period selector.
- Counts the timer's tick pulses up to a programmable target, then raises a maskable interrupt with a pending/acknowledge handshake.
- Supports one-shot and periodic modes; sits between the CPU register bus and the timer instance.

Parameters:
- CNT_W, 8, width of the tick target and of the internal tick counter.
- DATA_W, 8, register bus data width (≥ 5, since the control register uses bits 4:0).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  register write strobe, one cycle.
- addr  in  2  register select: 0 CTRL, 1 TARGET, 2 STATUS, 3 CAPTURE.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  combinational read data for addr.
- irq_ack  in  1  CPU acknowledge; clears pending.
- irq  out  1  pending AND CTRL.irq_en.
- tmr_tick  in  1  timer expiry output (may stay high several cycles).
- tmr_reset  out  1  active-high reset to timer.
- tmr_active  out  1  timer count enable.
- tmr_selector  out  3  timer period select (CTRL[4:2]).

Behaviour:
- Register map:
  - CTRL: bit0 enable, bit1 mode (0 one-shot, 1 periodic), bits4:2 selector. Other bits read 0.
  - TARGET: CNT_W bits. The event fires on tick number TARGET+1.
  - STATUS (read): bit0 pending, bit1 running, bit2 overrun. Writing 1 to bit2 clears overrun; other write bits are ignored.
- Reset values: CTRL=0, TARGET=0, tick_cnt=0, pending=0, overrun=0, state IDLE. Outputs irq=0, tmr_reset=1, tmr_active=0, tmr_selector=0, rdata=CTRL value (0).
- Tick detect: register tmr_tick once. tick_evt = tmr_tick & ~tmr_tick_q, so a pulse counts exactly once. tmr_tick_q resets to 0.
- FSM states:
  - IDLE: tmr_reset=1, tmr_active=0. A write with CTRL.enable=1 → ARM next cycle.
  - ARM (1 cycle): tmr_reset=1, tick_cnt←0 → RUN.
  - RUN: tmr_reset=0, tmr_active=1. On tick_evt, if tick_cnt==TARGET → FIRE, else tick_cnt+1.
  - FIRE (1 cycle): pending←1. If pending was already 1 and irq_ack is not asserted this cycle, overrun←1. Periodic → RUN with tick_cnt←0, timer not reset. One-shot → IDLE and CTRL.enable←0.
- running = (state==ARM or RUN or FIRE).
- CTRL write with enable=0 in any state → IDLE next cycle. Pending is kept.
- CTRL write changing selector or mode while running → ARM (restart). A write with identical bits is a no-op.
- TARGET write while running takes effect at the next compare. If tick_cnt > new TARGET, counting continues until tick_cnt wraps (2^CNT_W).
- irq_ack clears pending. If FIRE occurs in the same cycle as irq_ack, FIRE wins: pending=1 and overrun is unchanged.
- The irq_en mask does not affect pending. irq follows the mask combinationally from registers.
- Latency: tick_evt to pending=1 is 2 cycles (compare in RUN, set in FIRE); pending to irq is 0 cycles.
- Reset asserted mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro: TIMER_CTRL_CAPTURE_EN.
- Defined: on each FIRE, the CAPTURE register latches a CNT_W-bit free-running count of total fires (wraps at 2^CNT_W; resets to 0). Readable at addr 3.
- Undefined: addr 3 reads 0, and no capture logic is built.

Decomposition:
- Shared package timer_pkg:
  - Register address constants ADDR_CTRL/TARGET/STATUS/CAPTURE.
  - CTRL and STATUS bit index constants.
  - FSM state encoding constants IDLE/ARM/RUN/FIRE.
  - Selector period table, shared with the timer.
- One sub-module is natural: timer_edge_det (1-cycle rising-edge detector for tmr_tick).

Test Plan:
- Reset: hold reset=0 → irq=0, tmr_reset=1, tmr_active=0, STATUS reads 0.
- One-shot: TARGET=2, CTRL=0b00101 (sel=1, one-shot, enable) → 3 tick pulses raise pending 2 cycles after the third. CTRL.enable reads 0; irq=1 only if irq_en is set.
- Periodic with no ack: TARGET=0, mode=1, enable=1; 2 pulses → second FIRE sets overrun=1. Writing STATUS=0x04 clears it.
- Ack collision: assert irq_ack in the same cycle as FIRE → pending stays 1, overrun stays 0.
- Mid-run selector change: while RUN with tick_cnt=1, write sel 3→5 → one ARM cycle with tmr_reset=1 and tick_cnt=0; a long tmr_tick (5 cycles high) counts as one tick.
- Capture (macro defined): 4 periodic fires → CAPTURE=4. Async reset mid-RUN → all registers 0 with no clock edge needed.
